// File: rtl/data_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_responder_pkg
// Shared constants and types for the data-memory responder.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package data_ram_responder_pkg;

  // Pipeline-wide control constants
  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  // Upper bound of the wait-state parameter (fits the 4-bit counter)
  localparam int unsigned WAIT_MAX = 15;

  // Responder state encodings
  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_DONE = 2'd2
  } rsp_state_e;

  // A byte address is outside the RAM when any bit above the word index is set
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_responder_if.sv
// ---------------------------------------------------------------------------
// data_ram_responder_if
// Memory-access-stage request bus; names are from the responder's side.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface data_ram_responder_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        flush_i;
  logic [31:0] mem_data_o;
  logic        stall_o;
  logic        ack_o;
  logic        bus_err_o;

  // Pipeline memory-access stage
  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, flush_i,
    input  mem_data_o, stall_o, ack_o, bus_err_o
  );

  // Data RAM responder
  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, flush_i,
    output mem_data_o, stall_o, ack_o, bus_err_o
  );
endinterface

`default_nettype wire

// File: rtl/data_ram_responder_byte_en_ram.sv
// ---------------------------------------------------------------------------
// byte_en_ram
// Single-port word RAM with per-byte write enables and a registered read.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module byte_en_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  wire logic              clk,
  input  wire logic              en_i,
  input  wire logic              we_i,
  input  wire logic [3:0]        be_i,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [31:0]       wdata_i,
  output logic      [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Byte-masked write and full-word read-before-write on every enabled cycle
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int n = 0; n < 4; n++) begin
          if (be_i[n]) mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
// Services data-memory requests from an internal RAM after WAIT_CYCLES wait
// states, stalling the pipeline until completion; flags out-of-range
// addresses and honours flush while waiting.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,  // word-index width, at most 29
  parameter int unsigned WAIT_CYCLES = 2    // 0..WAIT_MAX
) (
  input wire logic            clk,
  input wire logic            rst,          // asynchronous, active-low
  data_ram_responder_if.slave bus
);

  rsp_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        req_we_q;
  logic [3:0]  req_sel_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_data_q;
  logic        ack_q;
  logic        bus_err_q;

  logic        accept;
  logic        wait_done;
  logic        commit;
  logic        acc_we;
  logic [3:0]  acc_sel;
  logic [31:0] acc_addr;
  logic [31:0] acc_data;
  logic        acc_oob;
  logic [31:0] ram_rdata;

  assign accept    = (state_q == RSP_IDLE) && (bus.mem_ce_i == ChipEnable) && !bus.flush_i;
  assign wait_done = (state_q == RSP_WAIT) && !bus.flush_i && (cnt_q == 4'd1);
  assign commit    = (rst != RstEnable) && (wait_done || (accept && (WAIT_CYCLES == 0)));

  // With zero wait states the access happens while still in IDLE, so it must
  // use the live request; otherwise it uses the request latched at accept.
  assign acc_we   = (state_q == RSP_IDLE) ? bus.mem_we_i   : req_we_q;
  assign acc_sel  = (state_q == RSP_IDLE) ? bus.mem_sel_i  : req_sel_q;
  assign acc_addr = (state_q == RSP_IDLE) ? bus.mem_addr_i : req_addr_q;
  assign acc_data = (state_q == RSP_IDLE) ? bus.mem_data_i : req_data_q;
  assign acc_oob  = addr_out_of_range(acc_addr, ADDR_W);

  byte_en_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (commit),
    .we_i    ((acc_we == WriteEnable) && !acc_oob),
    .be_i    (acc_sel),
    .addr_i  (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_data),
    .rdata_o (ram_rdata)
  );

  // Request FSM: latch in IDLE, count wait states, pulse ack in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RSP_IDLE;
      cnt_q      <= 4'd0;
      req_we_q   <= 1'b0;
      req_sel_q  <= 4'd0;
      req_addr_q <= 32'd0;
      req_data_q <= 32'd0;
      ack_q      <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        RSP_IDLE: begin
          if (accept) begin
            req_we_q   <= bus.mem_we_i;
            req_sel_q  <= bus.mem_sel_i;
            req_addr_q <= bus.mem_addr_i;
            req_data_q <= bus.mem_data_i;
            if (WAIT_CYCLES == 0) begin
              state_q   <= RSP_DONE;
              ack_q     <= 1'b1;
              bus_err_q <= acc_oob;
            end else begin
              state_q <= RSP_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        RSP_WAIT: begin
          if (bus.flush_i) begin
            state_q <= RSP_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q   <= RSP_DONE;
            cnt_q     <= 4'd0;
            ack_q     <= 1'b1;
            bus_err_q <= acc_oob;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RSP_DONE: state_q <= RSP_IDLE;
        default:  state_q <= RSP_IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and every wait state; never during reset
  assign bus.stall_o    = (rst != RstEnable) && (accept || (state_q == RSP_WAIT));
  assign bus.ack_o      = ack_q;
  assign bus.bus_err_o  = bus_err_q;
  assign bus.mem_data_o = (ack_q && !bus_err_q) ? ram_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
// Randomised scoreboard bench for two responder configurations
// (two wait states and zero wait states).
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_ram_responder;

  localparam int AW = 10;
  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct packed {
    int          due;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][1024];
  int          pool [20];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_ram_responder_if bus0 ();
  data_ram_responder_if bus1 ();

  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  data_ram_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int k, input logic ce, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data, input logic fl);
    if (k == 0) begin
      bus0.mem_ce_i = ce; bus0.mem_we_i = we; bus0.mem_sel_i = sel;
      bus0.mem_addr_i = addr; bus0.mem_data_i = data; bus0.flush_i = fl;
    end else begin
      bus1.mem_ce_i = ce; bus1.mem_we_i = we; bus1.mem_sel_i = sel;
      bus1.mem_addr_i = addr; bus1.mem_data_i = data; bus1.flush_i = fl;
    end
  endtask

  function automatic logic get_stall(input int k);
    return (k == 0) ? bus0.stall_o : bus1.stall_o;
  endfunction
  function automatic logic get_ack(input int k);
    return (k == 0) ? bus0.ack_o : bus1.ack_o;
  endfunction
  function automatic logic get_err(input int k);
    return (k == 0) ? bus0.bus_err_o : bus1.bus_err_o;
  endfunction
  function automatic logic [31:0] get_data(input int k);
    return (k == 0) ? bus0.mem_data_o : bus1.mem_data_o;
  endfunction

  // Reference model: a flat word array; bytes beyond 4*2**AW are a bus error
  function automatic exp_t model_req(input int k, input logic we, input logic [3:0] sel,
                                     input logic [31:0] addr, input logic [31:0] data, input int due);
    exp_t e;
    int   idx;
    e.due  = due;
    e.err  = (addr >= (32'd4 << AW));
    e.chk  = !we || e.err;
    e.data = 32'd0;
    if (!e.err) begin
      idx = int'(addr / 32'd4);
      if (we) begin
        for (int n = 0; n < 4; n++)
          if (sel[n]) mdl[k][idx][8*n +: 8] = data[8*n +: 8];
      end else begin
        e.data = mdl[k][idx];
      end
    end
    return e;
  endfunction

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic exp_t pop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Called on a negedge while the DUT is idle; flush_at=i aborts in wait cycle i
  task automatic issue(input int k, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data, input int flush_at);
    int w;
    int t;
    w = (k == 0) ? W0 : W1;
    t = cyc;
    drive(k, 1'b1, we, sel, addr, data, 1'b0);
    if (flush_at == 0) push(k, model_req(k, we, sel, addr, data, t + 1 + w));
    #1 check("stall_accept", 32'(get_stall(k)), 32'd1);
    for (int i = 1; i <= w + 1; i++) begin
      @(negedge clk);
      if (i == flush_at) begin
        drive(k, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
        #1 check("stall_flush_wait", 32'(get_stall(k)), 32'd1);
        @(negedge clk);
        drive(k, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
        #1 check("stall_after_flush", 32'(get_stall(k)), 32'd0);
        return;
      end
      if (i <= w)
        drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom, $urandom, 1'b0);
      else
        drive(k, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
      #1 check("stall_hold", 32'(get_stall(k)), (i <= w) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic req(input int k, input logic we, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] data, input int flush_at);
    issue(k, we, sel, addr, data, flush_at);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Monitor: every ack pops one expected response; idle outputs must be zero
  task automatic mon(input int k);
    exp_t e;
    int   qs;
    qs = (k == 0) ? q0.size() : q1.size();
    if (get_ack(k)) begin
      if (qs == 0) begin
        check("unexpected_ack", 32'(get_ack(k)), 32'd0);
      end else begin
        e = pop(k);
        check("ack_cycle", 32'(cyc), 32'(e.due));
        check("bus_err", 32'(get_err(k)), 32'(e.err));
        if (e.chk) check("rdata", get_data(k), e.data);
      end
    end else begin
      check("idle_bus_err", 32'(get_err(k)), 32'd0);
      check("idle_data", get_data(k), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic [31:0] a;
    int          fl;
    for (int i = 0; i < 16; i++) pool[i] = i;
    for (int i = 16; i < 20; i++) pool[i] = 1004 + i;

    // Reset: a pending chip enable must not raise stall
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_stall", 32'(get_stall(k)), 32'd0);
      check("rst_ack", 32'(get_ack(k)), 32'd0);
      check("rst_bus_err", 32'(get_err(k)), 32'd0);
      check("rst_data", get_data(k), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Preload every word the random phase may read
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < 2; k++)
        req(k, 1'b1, 4'hF, 32'(pool[i] * 4), $urandom, 0);

    // Directed cases, two wait states
    req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
    req(0, 1'b0, 4'hF, 32'h10, 32'd0, 0);
    req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 0);
    req(0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, 0);
    req(0, 1'b0, 4'hF, 32'h20, 32'd0, 0);
    req(0, 1'b1, 4'hF, 32'h30, 32'd0, 0);
    req(0, 1'b1, 4'hF, 32'h30, 32'hFFFFFFFF, 1);
    req(0, 1'b0, 4'hF, 32'h30, 32'd0, 0);
    req(0, 1'b0, 4'hF, 32'h1000, 32'd0, 0);
    req(0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 0);
    req(0, 1'b0, 4'hF, 32'h0, 32'd0, 0);
    req(0, 1'b0, 4'hF, 32'hFFC, 32'd0, 0);

    // Directed cases, zero wait states
    req(1, 1'b0, 4'hF, 32'h10, 32'd0, 0);
    req(1, 1'b1, 4'b0000, 32'h10, 32'h12345678, 0);
    req(1, 1'b0, 4'hF, 32'h10, 32'd0, 0);
    req(1, 1'b0, 4'hF, 32'h1000, 32'd0, 0);

    // Random traffic on both configurations
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 3))
            0:       a = 32'h1000;
            1:       a = 32'h1FFC;
            2:       a = 32'h80000000;
            default: a = $urandom | 32'h1000;
          endcase
        end else begin
          a = 32'(pool[$urandom_range(0, 19)] * 4 + $urandom_range(0, 3));
        end
        fl = (k == 0 && $urandom_range(0, 6) == 0) ? $urandom_range(1, W0) : 0;
        req(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, fl);
      end
    end

    // Reset during the wait of a write: nothing may be committed
    req(0, 1'b1, 4'hF, 32'h40, 32'h0BADC0DE, 0);
    drive(0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h55555555, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_stall", 32'(get_stall(0)), 32'd0);
    check("midrst_ack", 32'(get_ack(0)), 32'd0);
    drive(0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("midrst_ack_hold", 32'(get_ack(0)), 32'd0);
    check("midrst_data", get_data(0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    req(0, 1'b0, 4'hF, 32'h40, 32'd0, 0);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
